// File: rtl/switch_debounce.sv
// Two-flop synchronised, per-bit debounced switch conditioner with change pulses.
// Define SWITCH_DEBOUNCE_EN for the debounce FSMs; otherwise the bus is only synchronised.
module switch_debounce #(
    parameter int               WIDTH           = 10,
    parameter int               DEBOUNCE_CYCLES = 50000,
    parameter logic [WIDTH-1:0] RESET_VALUE     = '0
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [WIDTH-1:0] sw_in,
    output logic [WIDTH-1:0] sw_out,
    output logic [WIDTH-1:0] sw_edge,
    output logic             sw_changed
);

    logic [WIDTH-1:0] r_s1;
    logic [WIDTH-1:0] r_s2;
    logic [WIDTH-1:0] r_out;
    logic [WIDTH-1:0] r_edge;
    logic [WIDTH-1:0] w_take;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_s1 <= RESET_VALUE;
            r_s2 <= RESET_VALUE;
        end else begin
            r_s1 <= sw_in;
            r_s2 <= r_s1;
        end
    end

    // w_take marks bits whose debounced value adopts the synchronised input this edge.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_out  <= RESET_VALUE;
            r_edge <= '0;
        end else begin
            r_out  <= (r_out & ~w_take) | (r_s2 & w_take);
            r_edge <= w_take;
        end
    end

`ifdef SWITCH_DEBOUNCE_EN
    localparam int              CW    = $clog2(DEBOUNCE_CYCLES + 1);
    localparam logic [CW-1:0]   N_CNT = CW'(DEBOUNCE_CYCLES);

    typedef enum logic {
        ST_STABLE  = 1'b0,
        ST_PENDING = 1'b1
    } state_t;

    for (genvar g = 0; g < WIDTH; g++) begin : g_bit
        state_t        r_state;
        state_t        w_state_nxt;
        logic [CW-1:0] r_cnt;
        logic [CW-1:0] w_cnt_nxt;
        logic          w_mis;
        logic          w_take_bit;

        assign w_mis = r_s2[g] ^ r_out[g];

        always_ff @(posedge clk or posedge reset) begin
            if (reset) begin
                r_state <= ST_STABLE;
                r_cnt   <= '0;
            end else begin
                r_state <= w_state_nxt;
                r_cnt   <= w_cnt_nxt;
            end
        end

        // The count only runs while mismatched and stops at N, so it cannot wrap.
        always_comb begin
            w_state_nxt = r_state;
            w_cnt_nxt   = r_cnt;
            case (r_state)
                ST_STABLE: begin
                    if (w_mis) begin
                        w_state_nxt = ST_PENDING;
                        w_cnt_nxt   = CW'(1);
                    end else begin
                        w_cnt_nxt   = '0;
                    end
                end
                ST_PENDING: begin
                    if (!w_mis || (r_cnt == N_CNT)) begin
                        w_state_nxt = ST_STABLE;
                        w_cnt_nxt   = '0;
                    end else begin
                        w_cnt_nxt   = r_cnt + CW'(1);
                    end
                end
                default: begin
                    w_state_nxt = ST_STABLE;
                    w_cnt_nxt   = '0;
                end
            endcase
        end

        always_comb begin
            w_take_bit = (r_state == ST_PENDING) && w_mis && (r_cnt == N_CNT);
        end

        assign w_take[g] = w_take_bit;
    end
`else
    assign w_take = r_s2 ^ r_out;
`endif

    assign sw_out     = r_out;
    assign sw_edge    = r_edge;
    assign sw_changed = |r_edge;

endmodule

// File: tb/tb_switch_debounce.sv
// Bench for switch_debounce: run-length reference model feeding a scoreboard queue.
module tb_switch_debounce;

    localparam int W = 4;
`ifdef SWITCH_DEBOUNCE_EN
    localparam int EFF_N = 4;
`else
    localparam int EFF_N = 0;
`endif

    logic         clk = 1'b0;
    logic         reset;
    logic [W-1:0] sw_in;
    logic [W-1:0] sw_out;
    logic [W-1:0] sw_edge;
    logic         sw_changed;

    switch_debounce #(
        .WIDTH           (W),
        .DEBOUNCE_CYCLES (4),
        .RESET_VALUE     (4'h0)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .sw_in      (sw_in),
        .sw_out     (sw_out),
        .sw_edge    (sw_edge),
        .sw_changed (sw_changed)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [W-1:0] o;
        logic [W-1:0] e;
        logic         c;
    } exp_t;

    exp_t q[$];
    int   n_checks = 0;
    int   n_errors = 0;

    // Reference: each bit flips once N+1 consecutive samples, seen two edges late, disagree with it.
    logic [W-1:0] m_p1, m_p2, m_out, m_edge;
    int           m_run [W];

    task automatic model_reset();
        m_p1 = 4'h0; m_p2 = 4'h0; m_out = 4'h0; m_edge = 4'h0;
        for (int b = 0; b < W; b++) m_run[b] = 0;
    endtask

    task automatic model_edge(input logic [W-1:0] din, input logic rst);
        logic [W-1:0] seen;
        if (rst) begin
            model_reset();
        end else begin
            seen   = m_p2;
            m_p2   = m_p1;
            m_p1   = din;
            m_edge = 4'h0;
            for (int b = 0; b < W; b++) begin
                if (seen[b] != m_out[b]) begin
                    m_run[b]++;
                    if (m_run[b] >= EFF_N + 1) begin
                        m_out[b]  = seen[b];
                        m_edge[b] = 1'b1;
                        m_run[b]  = 0;
                    end
                end else begin
                    m_run[b] = 0;
                end
            end
        end
    endtask

    // One clock: model the edge with what the DUT saw, then drive the next inputs between edges.
    task automatic cyc(input logic [W-1:0] nxt_in, input logic nxt_rst);
        @(posedge clk);
        model_edge(sw_in, reset);
        #2;
        sw_in = nxt_in;
        reset = nxt_rst;
        if (nxt_rst) model_reset();
        q.push_back('{o: m_out, e: m_edge, c: |m_edge});
    endtask

    task automatic hold(input logic [W-1:0] v, input int k);
        for (int i = 0; i < k; i++) cyc(v, 1'b0);
    endtask

    task automatic check(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s at %0t: got %h expected %h", name, $time, act, exp);
        end
    endtask

    initial begin : monitor
        exp_t e;
        forever begin
            @(negedge clk);
            if (q.size() > 0) begin
                e = q.pop_front();
                check("sw_out", sw_out, e.o);
                check("sw_edge", sw_edge, e.e);
                check("sw_changed", {3'b000, sw_changed}, {3'b000, e.c});
            end
        end
    end

    initial begin : stimulus
        logic [W-1:0] cur;
        logic         rst;
        reset = 1'b1;
        sw_in = 4'hF;
        model_reset();

        // Reset dominates, then a held all-ones input is debounced after release.
        for (int i = 0; i < 3; i++) cyc(4'hF, 1'b1);
        hold(4'hF, 12);
        hold(4'h0, 12);

        // Pulse lengths around the acceptance threshold on bit0.
        hold(4'h1, EFF_N);       hold(4'h0, 12);
        hold(4'h1, EFF_N + 1);   hold(4'h0, 12);
        hold(4'h1, EFF_N + 2);   hold(4'h0, 12);
        hold(4'h1, 1);           hold(4'h0, 12);

        // Bounce on bit1 restarts the count.
        hold(4'h2, 1); hold(4'h0, 1); hold(4'h2, 12);
        hold(4'h0, 12);

        // Two bits stepping together.
        hold(4'hC, 12);
        hold(4'h0, 12);

        // Reset asserted between edges while bit0 is pending, then bit0 held after release.
        hold(4'h1, 4);
        cyc(4'h1, 1'b1);
        cyc(4'h1, 1'b0);
        hold(4'h1, 12);
        hold(4'h0, 12);

        // Random phase with long holds, multi-bit flips and rare resets.
        cur = 4'h0;
        for (int i = 0; i < 3000; i++) begin
            if ($urandom_range(0, 99) < 15) cur = cur ^ 4'($urandom);
            rst = ($urandom_range(0, 299) == 0);
            cyc(cur, rst);
        end
        hold(cur, 12);

        @(negedge clk);
        @(negedge clk);
        n_checks++;
        if (q.size() != 0) begin
            n_errors++;
            $display("FAIL scoreboard_drain: got %0d left expected 0", q.size());
        end
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
